// File: rtl/viterbi_mon_pkg.sv
// Shared types, default sizing and helpers for the Viterbi BER monitor.
package viterbi_mon_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int unsigned DEF_MAX_LAG = 64;
  localparam int unsigned LAG_W       = $clog2(DEF_MAX_LAG);

  // Adds inc to val and clamps the result at max_val instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] inc,
                                          input logic [63:0] max_val);
    logic [63:0] room;
    room = max_val - val;
    if (inc >= room) begin
      return max_val;
    end
    return val + inc;
  endfunction

endpackage

// File: rtl/ber_ref_delay.sv
// Reference bit history with a lag-selected tap for the BER monitor.
// hist_q[0] holds the previous sample's reference bit; lag 0 taps the live bit.
module ber_ref_delay
  import viterbi_mon_pkg::*;
#(
  parameter int unsigned MAX_LAG = DEF_MAX_LAG,
  parameter int unsigned LW      = LAG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic          ref_bit,
  input  logic [LW-1:0] lag,
  output logic          tap
);

  logic [MAX_LAG-1:0] hist_q;

  // Shift the current reference bit into the history on every sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else if (sample_en) begin
      hist_q <= {hist_q[MAX_LAG-2:0], ref_bit};
    end
  end

  // Pick the reference bit that lines up with the decoder at the current lag.
  always_comb begin
    tap = ref_bit;
    if (lag != '0) begin
      tap = hist_q[lag - LW'(1)];
    end
  end

endmodule

// File: rtl/viterbi_ber_monitor.sv
// Bit-error-rate monitor: finds the decoder latency by lag search, then counts
// compared bits and mismatches while aligned and flags loss of alignment.
module viterbi_ber_monitor
  import viterbi_mon_pkg::*;
#(
  parameter int unsigned MAX_LAG  = DEF_MAX_LAG,
  parameter int unsigned WIN      = 32,
  parameter int unsigned LOCK_THR = 2,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned CW       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en_i,
  input  logic                       ref_bit_i,
  input  logic                       dec_bit_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAG)-1:0] lag_o,
  output logic                       lost_o,
  output logic [CW-1:0]              bit_ct_o,
  output logic [CW-1:0]              err_ct_o,
  output logic [CW-1:0]              relock_ct_o
);

  localparam int unsigned LW       = $clog2(MAX_LAG);
  localparam int unsigned WW       = $clog2(WIN + 1);
  localparam logic [63:0] CNT_MAX  = (64'd1 << CW) - 64'd1;
  localparam logic [LW-1:0] LAG_LAST = LW'(MAX_LAG - 1);

  mon_state_t    state_q, state_d;
  logic [LW-1:0] lag_q, lag_next;
  logic [LW-1:0] fill_q;
  logic [WW-1:0] win_q, win_next;
  logic [WW-1:0] mis_q, mis_next;
  logic          lost_q;
  logic [CW-1:0] bit_ct_q, err_ct_q, relock_ct_q;

  logic tap;
  logic mismatch;
  logic search_abort, win_full, loss_hit;
  logic fill_adv, win_adv, win_clr, lag_adv, count_en, loss_evt;

  ber_ref_delay #(
    .MAX_LAG(MAX_LAG),
    .LW     (LW)
  ) u_ref_delay (
    .clk      (clk),
    .rst      (rst),
    .sample_en(sample_en_i),
    .ref_bit  (ref_bit_i),
    .lag      (lag_q),
    .tap      (tap)
  );

  assign mismatch     = dec_bit_i ^ tap;
  assign win_next     = win_q + 1'b1;
  assign mis_next     = mis_q + WW'(mismatch);
  assign search_abort = mis_next > WW'(LOCK_THR);
  assign win_full     = win_next == WW'(WIN);
  assign loss_hit     = mis_next > WW'(LOSS_THR);
  assign lag_next     = (lag_q == LAG_LAST) ? '0 : lag_q + 1'b1;

  // State register plus the lag, fill and window bookkeeping it steers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      lag_q   <= '0;
      fill_q  <= '0;
      win_q   <= '0;
      mis_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lost_q  <= loss_evt;
      if (fill_adv) begin
        fill_q <= fill_q + 1'b1;
      end
      if (lag_adv) begin
        lag_q <= lag_next;
      end
      if (win_clr) begin
        win_q <= '0;
        mis_q <= '0;
      end else if (win_adv) begin
        win_q <= win_next;
        mis_q <= mis_next;
      end
    end
  end

  // Next state: fill the history, search lags, then monitor the locked lag.
  always_comb begin
    state_d = state_q;
    if (sample_en_i) begin
      case (state_q)
        FILL:    if (fill_q == LAG_LAST) state_d = SEARCH;
        SEARCH:  if (!search_abort && win_full) state_d = LOCKED;
        LOCKED:  if (win_full && loss_hit) state_d = SEARCH;
        default: state_d = FILL;
      endcase
    end
  end

  // Per-sample control strobes and the registered status outputs.
  always_comb begin
    fill_adv = 1'b0;
    win_adv  = 1'b0;
    win_clr  = 1'b0;
    lag_adv  = 1'b0;
    count_en = 1'b0;
    loss_evt = 1'b0;
    if (sample_en_i) begin
      case (state_q)
        FILL: fill_adv = 1'b1;
        SEARCH: begin
          win_adv = 1'b1;
          if (search_abort) begin
            lag_adv = 1'b1;
            win_clr = 1'b1;
          end else if (win_full) begin
            win_clr = 1'b1;
          end
        end
        LOCKED: begin
          win_adv  = 1'b1;
          count_en = 1'b1;
          if (win_full) begin
            win_clr = 1'b1;
            if (loss_hit) begin
              lag_adv  = 1'b1;
              loss_evt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    locked_o    = (state_q == LOCKED);
    lag_o       = lag_q;
    lost_o      = lost_q;
    bit_ct_o    = bit_ct_q;
    err_ct_o    = err_ct_q;
    relock_ct_o = relock_ct_q;
  end

  // Saturating statistics; a clear in the same cycle discards that sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct_q    <= '0;
      err_ct_q    <= '0;
      relock_ct_q <= '0;
    end else if (clear_i) begin
      bit_ct_q    <= '0;
      err_ct_q    <= '0;
      relock_ct_q <= '0;
    end else begin
      if (count_en) begin
        bit_ct_q <= CW'(sat_inc(64'(bit_ct_q), 64'd1, CNT_MAX));
        err_ct_q <= CW'(sat_inc(64'(err_ct_q), {63'd0, mismatch}, CNT_MAX));
      end
      if (loss_evt) begin
        relock_ct_q <= CW'(sat_inc(64'(relock_ct_q), 64'd1, CNT_MAX));
      end
    end
  end

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Self-checking bench for viterbi_ber_monitor: a sample-level reference model
// is compared every cycle, with literal checkpoints for the key scenarios.
module tb_viterbi_ber_monitor;

  localparam int MAX_LAG  = 64;
  localparam int WIN      = 32;
  localparam int LOCK_THR = 2;
  localparam int LOSS_THR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en_i, ref_bit_i, dec_bit_i, clear_i;
  logic       locked_o, lost_o, locked8_o, lost8_o;
  logic [5:0] lag_o, lag8_o;
  logic [31:0] bit_ct_o, err_ct_o, relock_ct_o;
  logic [7:0]  bit8_o, err8_o, relock8_o;

  viterbi_ber_monitor dut (
    .clk(clk), .rst(rst), .sample_en_i(sample_en_i), .ref_bit_i(ref_bit_i),
    .dec_bit_i(dec_bit_i), .clear_i(clear_i), .locked_o(locked_o), .lag_o(lag_o),
    .lost_o(lost_o), .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o), .relock_ct_o(relock_ct_o)
  );

  viterbi_ber_monitor #(.CW(8)) dut_cw8 (
    .clk(clk), .rst(rst), .sample_en_i(sample_en_i), .ref_bit_i(ref_bit_i),
    .dec_bit_i(dec_bit_i), .clear_i(clear_i), .locked_o(locked8_o), .lag_o(lag8_o),
    .lost_o(lost8_o), .bit_ct_o(bit8_o), .err_ct_o(err8_o), .relock_ct_o(relock8_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;
  int lost_seen = 0;
  bit ref_log[$];

  // Reference model state, kept as plain integers and a queue.
  typedef enum int {M_FILL, M_SEARCH, M_LOCKED} mstate_t;
  mstate_t m_st;
  int      m_fill, m_lag, m_w, m_m;
  longint  m_bits, m_errs, m_relock;
  bit      m_lost;
  bit      m_hist[$];

  function automatic longint satv(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function void modelReset();
    m_st = M_FILL; m_fill = 0; m_lag = 0; m_w = 0; m_m = 0;
    m_bits = 0; m_errs = 0; m_relock = 0; m_lost = 0;
    m_hist.delete();
  endfunction

  function void modelStep(bit en, bit r, bit d, bit clr);
    bit tapv;
    int mis;
    m_lost = 0;
    if (clr) begin
      m_bits = 0; m_errs = 0; m_relock = 0;
    end
    if (!en) return;
    if (m_lag == 0) tapv = r;
    else if (m_lag - 1 < m_hist.size()) tapv = m_hist[m_lag-1];
    else tapv = 1'b0;
    mis = (tapv != d) ? 1 : 0;
    case (m_st)
      M_FILL: begin
        m_fill++;
        if (m_fill == MAX_LAG) begin m_st = M_SEARCH; m_lag = 0; end
      end
      M_SEARCH: begin
        m_w++; m_m += mis;
        if (m_m > LOCK_THR) begin
          m_lag = (m_lag + 1) % MAX_LAG; m_w = 0; m_m = 0;
        end else if (m_w == WIN) begin
          m_st = M_LOCKED; m_w = 0; m_m = 0;
        end
      end
      default: begin
        if (!clr) begin m_bits++; m_errs += mis; end
        m_w++; m_m += mis;
        if (m_w == WIN) begin
          if (m_m > LOSS_THR) begin
            m_st = M_SEARCH; m_lag = (m_lag + 1) % MAX_LAG; m_lost = 1;
            if (!clr) m_relock++;
          end
          m_w = 0; m_m = 0;
        end
      end
    endcase
    m_hist.push_front(r);
    if (m_hist.size() > MAX_LAG) void'(m_hist.pop_back());
  endfunction

  task automatic checkValue(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Full output comparison of both instances against the model.
  task automatic checkOutput();
    checkValue("locked", locked_o, (m_st == M_LOCKED) ? 1 : 0);
    checkValue("lag", lag_o, m_lag);
    checkValue("lost", lost_o, m_lost);
    checkValue("bit_ct", bit_ct_o, satv(m_bits, 32));
    checkValue("err_ct", err_ct_o, satv(m_errs, 32));
    checkValue("relock_ct", relock_ct_o, satv(m_relock, 32));
    checkValue("cw8_locked", locked8_o, (m_st == M_LOCKED) ? 1 : 0);
    checkValue("cw8_lag", lag8_o, m_lag);
    checkValue("cw8_lost", lost8_o, m_lost);
    checkValue("cw8_bit_ct", bit8_o, satv(m_bits, 8));
    checkValue("cw8_err_ct", err8_o, satv(m_errs, 8));
    checkValue("cw8_relock_ct", relock8_o, satv(m_relock, 8));
  endtask

  always @(negedge clk) begin
    if (cmp_en) checkOutput();
  end

  task automatic applyStimulus(input bit en, input bit r, input bit d, input bit clr);
    sample_en_i = en; ref_bit_i = r; dec_bit_i = d; clear_i = clr;
    @(posedge clk);
    #1;
    modelStep(en, r, d, clr);
    if (lost_o) lost_seen++;
  endtask

  // mode 0: clean, 1: flip every 16th dec bit, 2: complemented dec.
  task automatic runSamples(input int n, input int delay, input int mode, input bit clr);
    bit r, d;
    for (int i = 0; i < n; i++) begin
      r = 1'($urandom_range(0, 1));
      if (delay == 0) d = r;
      else if (ref_log.size() >= delay) d = ref_log[delay-1];
      else d = 1'b0;
      if (mode == 1 && (i % 16) == 15) d = ~d;
      if (mode == 2) d = ~d;
      ref_log.push_front(r);
      if (ref_log.size() > MAX_LAG) void'(ref_log.pop_back());
      applyStimulus(1'b1, r, d, clr);
      if ((i % 5) == 4) applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    sample_en_i = 0; ref_bit_i = 0; dec_bit_i = 0; clear_i = 0;
    #3 rst = 1'b0;
    modelReset();
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_locked", locked_o, 0);
    checkValue("reset_bit_ct", bit_ct_o, 0);
    rst = 1'b1;

    // Clean stream delayed by 10 samples.
    runSamples(416, 10, 0, 0);
    checkValue("lock_by_416", locked_o, 1);
    checkValue("lock_lag", lag_o, 10);
    runSamples(2000 - 416, 10, 0, 0);
    checkValue("clean_err_ct", err_ct_o, 0);

    // Sparse errors must be counted without losing lock.
    lost_seen = 0;
    runSamples(1024, 10, 1, 0);
    checkValue("sparse_err_ct", err_ct_o, 64);
    checkValue("sparse_locked", locked_o, 1);
    checkValue("sparse_no_loss", lost_seen, 0);

    // Line the next window up with the complemented burst.
    for (int k = 0; k < WIN && m_w != 0; k++) runSamples(1, 10, 0, 0);
    lost_seen = 0;
    runSamples(32, 10, 2, 0);
    checkValue("loss_pulses", lost_seen, 1);
    checkValue("loss_locked", locked_o, 0);
    checkValue("loss_relock_ct", relock_ct_o, 1);
    checkValue("loss_err_ct", err_ct_o, 96);

    // Relock on clean data, then clear alongside a sample.
    runSamples(2500, 10, 0, 0);
    checkValue("relocked", locked_o, 1);
    checkValue("relock_lag", lag_o, 10);
    runSamples(1, 10, 0, 1);
    checkValue("clear_bit_ct", bit_ct_o, 0);
    checkValue("clear_err_ct", err_ct_o, 0);
    checkValue("clear_relock_ct", relock_ct_o, 0);
    runSamples(1, 10, 0, 0);
    checkValue("after_clear_bit_ct", bit_ct_o, 1);

    // Asynchronous reset between clock edges while locked.
    runSamples(5, 10, 0, 0);
    #2 rst = 1'b0;
    modelReset();
    ref_log.delete();
    #1;
    checkValue("async_locked", locked_o, 0);
    checkValue("async_lag", lag_o, 0);
    checkValue("async_lost", lost_o, 0);
    checkValue("async_bit_ct", bit_ct_o, 0);
    checkValue("async_err_ct", err_ct_o, 0);
    checkValue("async_relock_ct", relock_ct_o, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Lag-0 clean stream: FILL, lock, then saturate the 8-bit instance.
    runSamples(64, 0, 0, 0);
    checkValue("fill_not_locked", locked_o, 0);
    runSamples(32, 0, 0, 0);
    checkValue("lag0_locked", locked_o, 1);
    checkValue("lag0_lag", lag_o, 0);
    runSamples(300, 0, 0, 0);
    checkValue("lag0_bit_ct", bit_ct_o, 300);
    checkValue("cw8_saturated", bit8_o, 255);
    checkValue("cw8_err_zero", err8_o, 0);

    @(posedge clk);
    #1 cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_monitor.md
Name: viterbi_ber_monitor

Overview:
- Bit-error-rate monitor downstream of the Viterbi decoder in the tx/rx testbench chain.
- Compares the decoded bit stream against the original encoder input stream and finds the decoder's unknown pipeline latency automatically by lag search.
- Once aligned, accumulates bit and error counts and reports loss of alignment.
- Lets the team measure decoder correction performance under injected channel errors without hand-tuning delays.

Parameters:
- MAX_LAG, 64, number of candidate lags (0..MAX_LAG-1); power of 2; also the depth of the reference history.
- WIN, 32, samples per evaluation window (search and locked monitoring).
- LOCK_THR, 2, maximum mismatches in a search window to declare lock.
- LOSS_THR, 8, mismatches in one locked window that exceed this declare loss.
- CW, 32, width of the bit, error and relock counters.

Ports:
- clk, input, 1, clock
- rst, input, 1, reset, asynchronous, active-low
- sample_en_i, input, 1, advances both streams one sample this cycle
- ref_bit_i, input, 1, encoder input bit for this sample
- dec_bit_i, input, 1, decoder output bit for this sample
- clear_i, input, 1, synchronous clear of the counters
- locked_o, output, 1, alignment found
- lag_o, output, clog2(MAX_LAG), current or locked lag
- lost_o, output, 1, one-cycle pulse on loss of lock
- bit_ct_o, output, CW, samples compared while locked
- err_ct_o, output, CW, mismatches while locked
- relock_ct_o, output, CW, number of loss events

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; history cleared.
  - State FILL; fill, window and mismatch counters 0.
- Only cycles with sample_en_i=1 advance any state; all other cycles hold.
- History:
  - hist shifts in ref_bit_i on each sample; hist[0] is the previous sample's reference bit.
  - tap = ref_bit_i when lag=0, else hist[lag-1].
  - mismatch = dec_bit_i ^ tap.
- FILL: count samples; after MAX_LAG samples go to SEARCH with lag=0. No comparisons are made in FILL.
- SEARCH:
  - Each sample: w++, m += mismatch.
  - If m > LOCK_THR (early abort): lag <= lag+1, wrapping MAX_LAG-1 -> 0; w, m <= 0.
  - Else if w reaches WIN: go to LOCKED, lag held, w and m cleared, locked_o=1 from the next cycle.
  - Abort takes priority over window completion on the same sample.
- LOCKED:
  - Each sample: bit_ct++, err_ct += mismatch, w++, m += mismatch.
  - When w reaches WIN: if m > LOSS_THR, go to SEARCH with lag <= lag+1 (wrapping), locked_o=0, lost_o pulse, relock_ct++. Otherwise stay locked. In both cases clear w and m.
  - bit_ct and err_ct retain their values on loss and resume accumulating after relock.
- Counters saturate at 2^CW-1, with no wrap.
- clear_i:
  - Zeroes bit_ct, err_ct and relock_ct only; state, lag and window counters are unaffected.
  - If clear_i and a counted sample occur in the same cycle, clear wins and that sample is not counted.
- Reset mid-operation: immediate return to the reset state, including FILL.

Decomposition:
- Package viterbi_mon_pkg: state enum {FILL, SEARCH, LOCKED}, lag width localparam, and a saturating-increment function.
- Sub-module ber_ref_delay: reference history plus lag tap mux.
- FSM and counters stay in the top.

Test Plan:
- Clean stream, dec = ref delayed 10 samples, 2000 samples:
  - locked_o=1 and lag_o=10 before sample 64+10*WIN+WIN.
  - err_ct_o=0; bit_ct_o equals the number of locked samples.
- After lock, flip every 16th dec bit for 1024 samples: err_ct_o=64, locked_o stays 1, lost_o never pulses.
- After lock, replace dec with the complement of ref:
  - Within 32 samples, lost_o pulses exactly once, locked_o=0, relock_ct_o=1.
  - bit_ct_o and err_ct_o keep their pre-loss values plus that final window.
- CW=8, clean lag-0 stream: after 300 locked samples, bit_ct_o=255 (saturated) and err_ct_o=0.
- clear_i asserted with sample_en_i while locked:
  - Next cycle all three counters are 0.
  - One further sample gives bit_ct_o=1.
- Assert rst low mid-lock between clock edges:
  - All outputs 0 immediately.
  - After release, no lock before MAX_LAG samples (FILL).
